// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback controller for an external combinational 8-bit ALU.
// Accepts 9-bit instructions (opcode/rd/rs-imm), sources operands from an 8-entry
// register file, writes back ALU results or flags, and runs load/store through a
// request/acknowledge memory port that has a bounded wait.
module alu_sequencer #(
    parameter int DW          = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [8:0]    instr,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_neg,
    input  logic          alu_zero,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          op_done,
    output logic          flag_neg,
    output logic          flag_zero,
    output logic          err,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int CW = $clog2(MEM_TIMEOUT);

    localparam logic [3:0] OP_CMP  = 4'b0110;
    localparam logic [3:0] OP_CMPI = 4'b0111;
    localparam logic [3:0] OP_MVI  = 4'b1001;
    localparam logic [3:0] OP_LDR  = 4'b1010;
    localparam logic [3:0] OP_STR  = 4'b1011;
    localparam logic [3:0] OP_LSI  = 4'b1100;
    localparam logic [3:0] OP_ORI  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MEM  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [8:0]      r_instr;
    logic [DW-1:0]   r_rf [0:7];
    logic [CW-1:0]   r_cnt;

    logic [3:0]      w_op;
    logic [2:0]      w_rd;
    logic [1:0]      w_rs;
    logic [DW-1:0]   w_imm;
    logic            w_is_imm;
    logic            w_is_cmp;
    logic            w_is_mem;
    logic            w_timeout;

    // Decode fields of the latched instruction
    assign w_op      = r_instr[8:5];
    assign w_rd      = r_instr[4:2];
    assign w_rs      = r_instr[1:0];
    assign w_imm     = {{(DW-2){1'b0}}, r_instr[1:0]};
    assign w_is_imm  = (w_op == OP_CMPI) || (w_op == OP_MVI) ||
                       (w_op == OP_LSI)  || (w_op == OP_ORI);
    assign w_is_cmp  = (w_op == OP_CMP) || (w_op == OP_CMPI);
    assign w_is_mem  = (w_op == OP_LDR) || (w_op == OP_STR);
    assign w_timeout = (r_cnt == CW'(MEM_TIMEOUT - 1));

    // ALU drive is purely combinational from the latched instruction in every state
    assign alu_op   = w_op;
    assign alu_a    = r_rf[w_rd];
    assign alu_b    = w_is_imm ? w_imm : r_rf[{1'b0, w_rs}];
    assign dbg_data = r_rf[dbg_addr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a memory op leaves MEM on ack or when the wait bound expires
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (instr_valid) w_next = S_EXEC;
            S_EXEC: w_next = w_is_mem ? S_MEM : S_IDLE;
            S_MEM:  if (mem_ack || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: ready only while idle
    always_comb begin
        instr_ready = (r_state == S_IDLE);
    end

    // Datapath: instruction latch, register file writeback, flags, memory port, timeout count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= '0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
            r_cnt     <= '0;
            flag_neg  <= 1'b0;
            flag_zero <= 1'b0;
            err       <= 1'b0;
            op_done   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            op_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) r_instr <= instr;
                end
                S_EXEC: begin
                    if (w_is_cmp) begin
                        flag_neg  <= alu_neg;
                        flag_zero <= alu_zero;
                        op_done   <= 1'b1;
                    end else if (w_is_mem) begin
                        mem_addr  <= alu_rslt;
                        mem_wdata <= r_rf[w_rd];
                        mem_we    <= (w_op == OP_STR);
                        mem_req   <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_rf[w_rd] <= alu_rslt;
                        op_done    <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (w_op == OP_LDR) r_rf[w_rd] <= mem_rdata;
                        mem_req <= 1'b0;
                        op_done <= 1'b1;
                    end else if (w_timeout) begin
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        op_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
